// File: rtl/wb_arb2.sv
// wb_arb2: two-master / one-slave Wishbone classic arbiter.
//
// Master 0 is the core data port and master 1 is the debug/DMA port. Both share
// one peripheral slave. Ownership is round-robin and is held for the whole bus
// cycle, which lasts as long as the owner's cyc is high. An optional ack
// timeout ends a hung cycle with a one-cycle err pulse to the owner.
//
// Handshake: a master requests by raising mX_cyc_i. Each beat is mX_stb_i high
// until the cycle where mX_ack_o or mX_err_o is high. Ack and rdata come
// straight from the slave, with no register stage. Err comes only from the
// timeout.
//
// Ports:
//   clk, rst          clock; synchronous active-high reset
//   mX_cyc_i/stb_i/we_i/addr_i/wdata_i/sel_i   master X request
//   mX_rdata_o/ack_o/err_o                     master X response
//   s_cyc_o/stb_o/we_o/addr_o/wdata_o/sel_o    slave request (owner's signals)
//   s_rdata_i/ack_i                            slave response
//   grant_o           one-hot owner {m1,m0}; 00 when idle
//   dbg_state_o       FSM state (0 idle, 1 busy, 2 abort, 3 drain)
module wb_arb2 #(
  parameter int WB_AD_WIDTH  = 32,
  parameter int WB_DAT_WIDTH = 32,
  parameter int TIMEOUT      = 64
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      m0_cyc_i,
  input  logic                      m0_stb_i,
  input  logic                      m0_we_i,
  input  logic [WB_AD_WIDTH-1:0]    m0_addr_i,
  input  logic [WB_DAT_WIDTH-1:0]   m0_wdata_i,
  input  logic [WB_DAT_WIDTH/8-1:0] m0_sel_i,
  output logic [WB_DAT_WIDTH-1:0]   m0_rdata_o,
  output logic                      m0_ack_o,
  output logic                      m0_err_o,
  input  logic                      m1_cyc_i,
  input  logic                      m1_stb_i,
  input  logic                      m1_we_i,
  input  logic [WB_AD_WIDTH-1:0]    m1_addr_i,
  input  logic [WB_DAT_WIDTH-1:0]   m1_wdata_i,
  input  logic [WB_DAT_WIDTH/8-1:0] m1_sel_i,
  output logic [WB_DAT_WIDTH-1:0]   m1_rdata_o,
  output logic                      m1_ack_o,
  output logic                      m1_err_o,
  output logic                      s_cyc_o,
  output logic                      s_stb_o,
  output logic                      s_we_o,
  output logic [WB_AD_WIDTH-1:0]    s_addr_o,
  output logic [WB_DAT_WIDTH-1:0]   s_wdata_o,
  output logic [WB_DAT_WIDTH/8-1:0] s_sel_o,
  input  logic [WB_DAT_WIDTH-1:0]   s_rdata_i,
  input  logic                      s_ack_i,
  output logic [1:0]                grant_o,
  output logic [1:0]                dbg_state_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    ABORT = 2'd2,
    DRAIN = 2'd3
  } state_t;

  // The stall counter is compared against the last count before an abort.
  // That value is forced to 0 when the timeout is disabled, because the abort
  // branch is never taken in that case.
  localparam logic [7:0] CNT_LAST = (TIMEOUT > 0) ? 8'(TIMEOUT - 1) : 8'd0;

  state_t     state, state_nx;
  logic       owner, owner_nx;           // 0 = m0, 1 = m1
  logic       last_grant, last_grant_nx; // previous owner; loses the next tie
  logic [7:0] cnt, cnt_nx;               // consecutive stalled beats
  logic       own_cyc, own_stb;

  assign own_cyc     = owner ? m1_cyc_i : m0_cyc_i;
  assign own_stb     = owner ? m1_stb_i : m0_stb_i;
  assign dbg_state_o = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      owner      <= 1'b0;
      last_grant <= 1'b1;
      cnt        <= 8'd0;
    end else begin
      state      <= state_nx;
      owner      <= owner_nx;
      last_grant <= last_grant_nx;
      cnt        <= cnt_nx;
    end
  end

  // Next-state logic. The counter clears by default. It holds a nonzero
  // value only while BUSY stays BUSY with the owner stalled.
  always_comb begin
    state_nx      = state;
    owner_nx      = owner;
    last_grant_nx = last_grant;
    cnt_nx        = 8'd0;
    case (state)
      IDLE: begin
        if (m0_cyc_i && m1_cyc_i) begin
          owner_nx = ~last_grant;
          state_nx = BUSY;
        end else if (m0_cyc_i) begin
          owner_nx = 1'b0;
          state_nx = BUSY;
        end else if (m1_cyc_i) begin
          owner_nx = 1'b1;
          state_nx = BUSY;
        end
      end
      BUSY: begin
        if (!own_cyc) begin
          // Passing through IDLE keeps a late ack away from the next owner.
          state_nx      = IDLE;
          last_grant_nx = owner;
        end else if ((TIMEOUT > 0) && own_stb && !s_ack_i) begin
          if (cnt == CNT_LAST) state_nx = ABORT;
          else                 cnt_nx   = cnt + 8'd1;
        end
      end
      ABORT: begin
        if (!own_cyc) begin
          state_nx      = IDLE;
          last_grant_nx = owner;
        end else begin
          state_nx = DRAIN;
        end
      end
      DRAIN: begin
        if (!own_cyc) begin
          state_nx      = IDLE;
          last_grant_nx = owner;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Output steering. The slave sees the owner only in BUSY. ABORT and DRAIN
  // hold the bus with cyc low until the owner gives up. Any slave ack in
  // those states is dropped.
  always_comb begin
    s_cyc_o    = 1'b0;
    s_stb_o    = 1'b0;
    s_we_o     = 1'b0;
    s_addr_o   = '0;
    s_wdata_o  = '0;
    s_sel_o    = '0;
    m0_rdata_o = '0;
    m0_ack_o   = 1'b0;
    m0_err_o   = 1'b0;
    m1_rdata_o = '0;
    m1_ack_o   = 1'b0;
    m1_err_o   = 1'b0;
    grant_o    = 2'b00;
    if (state != IDLE) grant_o = owner ? 2'b10 : 2'b01;
    if (state == BUSY) begin
      if (owner) begin
        s_cyc_o    = m1_cyc_i;
        s_stb_o    = m1_stb_i;
        s_we_o     = m1_we_i;
        s_addr_o   = m1_addr_i;
        s_wdata_o  = m1_wdata_i;
        s_sel_o    = m1_sel_i;
        m1_ack_o   = s_ack_i;
        m1_rdata_o = s_rdata_i;
      end else begin
        s_cyc_o    = m0_cyc_i;
        s_stb_o    = m0_stb_i;
        s_we_o     = m0_we_i;
        s_addr_o   = m0_addr_i;
        s_wdata_o  = m0_wdata_i;
        s_sel_o    = m0_sel_i;
        m0_ack_o   = s_ack_i;
        m0_rdata_o = s_rdata_i;
      end
    end
    if (state == ABORT) begin
      m0_err_o = ~owner;
      m1_err_o = owner;
    end
  end

endmodule

// File: tb/tb_wb_arb2.sv
// tb_wb_arb2: self-checking bench for wb_arb2 (32-bit bus, TIMEOUT = 16).
// A reference model predicts every output vector of each cycle. The model
// tracks the owner, a gap after release, and a stalled-beat count. Predicted
// vectors go into exp_q. A negedge monitor pops each vector and compares it
// against the DUT. The directed scenarios add point checks against constants.
module tb_wb_arb2;

  localparam int TO = 16;
  localparam int VW = 141;

  logic        clk = 1'b0;
  logic        rst;
  logic        m0_cyc_i, m0_stb_i, m0_we_i, m1_cyc_i, m1_stb_i, m1_we_i;
  logic [31:0] m0_addr_i, m0_wdata_i, m1_addr_i, m1_wdata_i;
  logic [3:0]  m0_sel_i, m1_sel_i;
  logic [31:0] m0_rdata_o, m1_rdata_o;
  logic        m0_ack_o, m0_err_o, m1_ack_o, m1_err_o;
  logic        s_cyc_o, s_stb_o, s_we_o;
  logic [31:0] s_addr_o, s_wdata_o;
  logic [3:0]  s_sel_o;
  logic [31:0] s_rdata_i;
  logic        s_ack_i;
  logic [1:0]  grant_o, dbg_state_o;

  wb_arb2 #(.WB_AD_WIDTH(32), .WB_DAT_WIDTH(32), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i), .m0_we_i(m0_we_i),
    .m0_addr_i(m0_addr_i), .m0_wdata_i(m0_wdata_i), .m0_sel_i(m0_sel_i),
    .m0_rdata_o(m0_rdata_o), .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o),
    .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i), .m1_we_i(m1_we_i),
    .m1_addr_i(m1_addr_i), .m1_wdata_i(m1_wdata_i), .m1_sel_i(m1_sel_i),
    .m1_rdata_o(m1_rdata_o), .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o),
    .s_addr_o(s_addr_o), .s_wdata_o(s_wdata_o), .s_sel_o(s_sel_o),
    .s_rdata_i(s_rdata_i), .s_ack_i(s_ack_i),
    .grant_o(grant_o), .dbg_state_o(dbg_state_o)
  );

  // Clock and reset.
  always #5 clk = ~clk;

  // Stimulus state. The model reads these variables, not the DUT pins.
  logic [1:0]  cyc, stb, we;
  logic [31:0] addr [2];
  logic [31:0] wdata [2];
  logic [3:0]  sel [2];
  logic        ack_v, rst_v;
  logic [31:0] rdata_v;

  // Scoreboard.
  logic [VW-1:0] exp_q [$];
  int n_checks = 0;
  int n_errors = 0;

  // Reference model. md_owner is -1 when the bus is free. md_err_now marks
  // the single error cycle. md_drain marks the wait for the aborted owner to
  // drop cyc. md_wait counts stalled beats in a row.
  int md_owner, md_last, md_wait;
  bit md_err_now, md_drain;

  function automatic logic [VW-1:0] pack(input logic [1:0] g, input logic sc, ss, sw,
                                         input logic [31:0] sa, swd, input logic [3:0] ssel,
                                         input logic a0, e0, input logic [31:0] r0,
                                         input logic a1, e1, input logic [31:0] r1);
    return {g, sc, ss, sw, sa, swd, ssel, a0, e0, r0, a1, e1, r1};
  endfunction

  function automatic logic [VW-1:0] predict();
    logic [1:0] g;
    logic sc, ss, sw, a0, e0, a1, e1;
    logic [31:0] sa, swd, r0, r1;
    logic [3:0] ssel;
    bit busy;
    g = 2'b00; sc = 0; ss = 0; sw = 0; sa = 0; swd = 0; ssel = 0;
    a0 = 0; e0 = 0; r0 = 0; a1 = 0; e1 = 0; r1 = 0;
    busy = (md_owner >= 0) && !md_err_now && !md_drain;
    if (md_owner == 0) g = 2'b01;
    if (md_owner == 1) g = 2'b10;
    if (busy) begin
      sc = cyc[md_owner]; ss = stb[md_owner]; sw = we[md_owner];
      sa = addr[md_owner]; swd = wdata[md_owner]; ssel = sel[md_owner];
      if (md_owner == 0) begin a0 = ack_v; r0 = rdata_v; end
      else begin a1 = ack_v; r1 = rdata_v; end
    end
    if (md_err_now) begin
      e0 = (md_owner == 0);
      e1 = (md_owner == 1);
    end
    return pack(g, sc, ss, sw, sa, swd, ssel, a0, e0, r0, a1, e1, r1);
  endfunction

  task automatic release_bus();
    md_last = md_owner; md_owner = -1; md_drain = 0; md_wait = 0;
  endtask

  task automatic model_update();
    if (rst_v) begin
      md_owner = -1; md_last = 1; md_wait = 0; md_err_now = 0; md_drain = 0;
    end else if (md_owner < 0) begin
      md_wait = 0;
      if (cyc == 2'b11)  md_owner = (md_last == 1) ? 0 : 1;
      else if (cyc[0])   md_owner = 0;
      else if (cyc[1])   md_owner = 1;
    end else if (md_err_now) begin
      md_err_now = 0;
      if (!cyc[md_owner]) release_bus();
      else md_drain = 1;
    end else if (!cyc[md_owner]) begin
      release_bus();
    end else if (!md_drain) begin
      if (stb[md_owner] && !ack_v) begin
        md_wait++;
        if (TO > 0 && md_wait == TO) begin md_err_now = 1; md_wait = 0; end
      end else begin
        md_wait = 0;
      end
    end
  endtask

  // Driver tasks: apply() drives one cycle of inputs and queues the expected
  // outputs for that cycle. adv() moves to the next clock edge.
  task automatic apply();
    rst = rst_v;
    m0_cyc_i = cyc[0]; m0_stb_i = stb[0]; m0_we_i = we[0];
    m0_addr_i = addr[0]; m0_wdata_i = wdata[0]; m0_sel_i = sel[0];
    m1_cyc_i = cyc[1]; m1_stb_i = stb[1]; m1_we_i = we[1];
    m1_addr_i = addr[1]; m1_wdata_i = wdata[1]; m1_sel_i = sel[1];
    s_ack_i = ack_v; s_rdata_i = rdata_v;
    exp_q.push_back(predict());
  endtask

  task automatic adv();
    @(posedge clk); #1;
    model_update();
  endtask

  task automatic idle_inputs();
    cyc = 0; stb = 0; we = 0; ack_v = 0; rst_v = 0; rdata_v = 0;
    for (int i = 0; i < 2; i++) begin addr[i] = 0; wdata[i] = 0; sel[i] = 4'hF; end
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: compares the DUT against the queued prediction every cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [VW-1:0] e, a;
      e = exp_q.pop_front();
      a = pack(grant_o, s_cyc_o, s_stb_o, s_we_o, s_addr_o, s_wdata_o, s_sel_o,
               m0_ack_o, m0_err_o, m0_rdata_o, m1_ack_o, m1_err_o, m1_rdata_o);
      n_checks++;
      if (a !== e) begin
        n_errors++;
        $display("FAIL cycle_outputs t=%0t got %h expected %h", $time, a, e);
      end
    end
  end

  int stb_cyc, err_cyc, n_err, n_ack, len [2], hang;

  initial begin
    idle_inputs();
    rst_v = 1;
    rst = 1; m0_cyc_i = 0; m0_stb_i = 0; m0_we_i = 0; m0_addr_i = 0; m0_wdata_i = 0;
    m0_sel_i = 0; m1_cyc_i = 0; m1_stb_i = 0; m1_we_i = 0; m1_addr_i = 0;
    m1_wdata_i = 0; m1_sel_i = 0; s_ack_i = 0; s_rdata_i = 0;
    repeat (3) @(posedge clk);
    #1; model_update();
    apply(); #1;
    chk("reset_grant", 64'(grant_o), 64'h0);
    chk("reset_s_cyc", 64'(s_cyc_o), 64'h0);
    adv();
    rst_v = 0;

    // Single m0 read.
    cyc = 2'b01; stb = 2'b01; addr[0] = 32'h0200_BFF8;
    apply(); #1; chk("read_req_s_cyc", 64'(s_cyc_o), 64'h0); adv();
    apply(); #1; chk("read_s_cyc", 64'(s_cyc_o), 64'h1);
    chk("read_s_addr", 64'(s_addr_o), 64'h0200_BFF8); adv();
    ack_v = 1; rdata_v = 32'h1234;
    apply(); #1;
    chk("read_ack", 64'(m0_ack_o), 64'h1);
    chk("read_rdata", 64'(m0_rdata_o), 64'h1234);
    chk("read_m1_quiet", 64'({m1_ack_o, m1_err_o, m1_rdata_o}), 64'h0);
    chk("read_grant", 64'(grant_o), 64'h1);
    adv();
    idle_inputs(); apply(); adv(); apply(); adv();

    // Tie after reset, then the next tie alternates.
    rst_v = 1; apply(); adv(); rst_v = 0;
    cyc = 2'b11; stb = 2'b11;
    apply(); adv();
    ack_v = 1; apply(); #1; chk("tie1_grant", 64'(grant_o), 64'h1); adv();
    ack_v = 0; cyc = 2'b10; stb = 2'b10;
    apply(); adv();
    apply(); #1; chk("tie_gap_grant", 64'(grant_o), 64'h0); adv();
    apply(); #1; chk("tie2_grant", 64'(grant_o), 64'h2); adv();
    cyc = 0; stb = 0; apply(); adv(); apply(); adv();
    cyc = 2'b11; stb = 2'b11; apply(); adv();
    apply(); #1; chk("tie3_grant", 64'(grant_o), 64'h1); adv();
    cyc = 0; stb = 0; apply(); adv(); apply(); adv();

    // Back-to-back m1 writes while m0 keeps requesting.
    cyc = 2'b11; stb = 2'b11; we = 2'b11; wdata[1] = 32'hA5; wdata[0] = 32'h77;
    apply(); adv();
    ack_v = 1; apply(); #1;
    chk("b2b_grant", 64'(grant_o), 64'h2);
    chk("b2b_wdata1", 64'(s_wdata_o), 64'hA5);
    adv();
    wdata[1] = 32'h5A; apply(); #1;
    chk("b2b_wdata2", 64'(s_wdata_o), 64'h5A);
    chk("b2b_acks", 64'({m1_ack_o, m0_ack_o}), 64'h2);
    adv();
    ack_v = 0; cyc = 2'b01; stb = 2'b01;
    apply(); adv();
    apply(); #1; chk("b2b_gap_grant", 64'(grant_o), 64'h0); adv();
    apply(); #1; chk("b2b_m0_grant", 64'(grant_o), 64'h1); adv();
    idle_inputs(); apply(); adv(); apply(); adv();

    // Hung slave: m1 stalls until the timeout fires.
    cyc = 2'b10; stb = 2'b10; addr[1] = 32'h0200_4000;
    stb_cyc = -1; err_cyc = -1; n_err = 0;
    for (int k = 0; k < 30; k++) begin
      apply(); #1;
      if (s_stb_o && stb_cyc < 0) stb_cyc = k;
      if (m1_err_o) begin n_err++; if (err_cyc < 0) err_cyc = k; end
      adv();
    end
    chk("hung_err_offset", 64'(err_cyc - stb_cyc), 64'd16);
    chk("hung_err_count", 64'(n_err), 64'd1);
    apply(); #1;
    chk("hung_grant_held", 64'(grant_o), 64'h2);
    chk("hung_s_cyc", 64'(s_cyc_o), 64'h0);
    adv();
    cyc = 0; stb = 0; apply(); adv(); apply(); adv();

    // Ack in the last stalled beat before the timeout, twice in a row.
    cyc = 2'b01; stb = 2'b01; n_ack = 0; n_err = 0;
    for (int k = 0; k < 34; k++) begin
      ack_v = (k == 16 || k == 32);
      apply(); #1;
      if (m0_ack_o) n_ack++;
      if (m0_err_o) n_err++;
      adv();
    end
    chk("edge_ack_count", 64'(n_ack), 64'd2);
    chk("edge_err_count", 64'(n_err), 64'd0);
    idle_inputs(); apply(); adv(); apply(); adv();

    // Reset during an m0 transfer.
    cyc = 2'b01; stb = 2'b01; apply(); adv();
    apply(); #1; chk("rst_pre_grant", 64'(grant_o), 64'h1); adv();
    rst_v = 1; apply(); adv();
    rst_v = 0; ack_v = 1; cyc = 0; stb = 0;
    apply(); #1;
    chk("rst_s_cyc", 64'(s_cyc_o), 64'h0);
    chk("rst_grant", 64'(grant_o), 64'h0);
    chk("rst_term", 64'({m0_ack_o, m0_err_o, m1_ack_o, m1_err_o}), 64'h0);
    adv();
    ack_v = 0; cyc = 2'b11; stb = 2'b11; apply(); adv();
    apply(); #1; chk("rst_tie_grant", 64'(grant_o), 64'h1); adv();
    idle_inputs(); apply(); adv(); apply(); adv();

    // Randomized traffic with stalls, long hangs and occasional resets.
    len[0] = 0; len[1] = 0; hang = 0;
    for (int c = 0; c < 4000; c++) begin
      for (int m = 0; m < 2; m++) begin
        if (len[m] == 0) begin
          cyc[m] = 0; stb[m] = 0;
          if ($urandom_range(0, 3) == 0) len[m] = $urandom_range(1, 40);
        end else begin
          cyc[m] = 1; len[m]--;
          stb[m] = ($urandom_range(0, 9) != 0);
          we[m] = 1'($urandom); addr[m] = $urandom; wdata[m] = $urandom;
          sel[m] = 4'($urandom);
        end
      end
      if (hang > 0) begin
        ack_v = 0; hang--;
      end else begin
        ack_v = ($urandom_range(0, 2) == 0);
        if ($urandom_range(0, 40) == 0) hang = $urandom_range(10, 25);
      end
      rdata_v = $urandom;
      rst_v = ($urandom_range(0, 400) == 0);
      apply(); adv();
    end
    idle_inputs(); apply(); adv(); apply(); adv();
    @(negedge clk); #1;
    chk("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
